// File: rtl/pmem_arbiter.sv
// pmem_arbiter: shares the line-wide physical-memory port between icache and dcache.
// Define PMEM_ARB_RR_EN for round-robin on conflict; default is dcache-over-icache priority.
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pm_read,
    output logic              pm_write,
    output logic [ADDR_W-1:0] pm_address,
    output logic [LINE_W-1:0] pm_wdata,
    input  logic [LINE_W-1:0] pm_rdata,
    input  logic              pm_resp
);
    localparam int OFF = $clog2(LINE_W / 8);
    localparam logic [ADDR_W-1:0] OFF_MASK = {{(ADDR_W - OFF){1'b0}}, {OFF{1'b1}}};

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t            state_q;
    logic              pm_read_q, pm_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              d_req, i_req, grant_d;

    assign d_req = d_read | d_write;
    assign i_req = i_read;

`ifdef PMEM_ARB_RR_EN
    logic last_owner_q; // 1 = dcache won the most recent completed transaction
    assign grant_d = d_req & (~i_req | ~last_owner_q);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_owner_q <= 1'b0;
        else if (state_q != IDLE && pm_resp)
            last_owner_q <= (state_q == SERVE_D);
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pm_read_q  <= 1'b0;
            pm_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (state_q == IDLE) begin
            if (d_req | i_req) begin
                state_q    <= grant_d ? SERVE_D : SERVE_I;
                pm_read_q  <= grant_d ? ~d_write : 1'b1;
                pm_write_q <= grant_d & d_write;
                addr_q     <= (grant_d ? d_address : i_address) & ~OFF_MASK;
                wdata_q    <= d_wdata;
            end
        end else if (pm_resp) begin
            state_q    <= IDLE;
            pm_read_q  <= 1'b0;
            pm_write_q <= 1'b0;
        end
    end

    assign pm_read    = pm_read_q;
    assign pm_write   = pm_write_q;
    assign pm_address = addr_q;
    assign pm_wdata   = wdata_q;
    assign i_rdata    = pm_rdata;
    assign d_rdata    = pm_rdata;
    assign i_resp     = (state_q == SERVE_I) & pm_resp;
    assign d_resp     = (state_q == SERVE_D) & pm_resp;

`ifndef SYNTHESIS
    a_no_rw_both: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
    a_no_idle_resp: assert property (@(posedge clk) disable iff (rst) !(state_q == IDLE && pm_resp));
    a_one_dir: assert property (@(posedge clk) disable iff (rst) !(pm_read && pm_write));
`endif
endmodule

// File: tb/tb_pmem_arbiter.sv
// tb_pmem_arbiter: directed checks of grant order, latching, latency and reset abort.
module tb_pmem_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [31:0]  i_address = '0, d_address = '0;
    logic [255:0] d_wdata = '0, pm_rdata = '0;
    logic [255:0] i_rdata, d_rdata, pm_wdata;
    logic [31:0]  pm_address;
    logic         i_resp, d_resp, pm_read, pm_write, pm_resp;

    int n_tests = 0, n_fail = 0;
    int lat = 4, cnt;
    int rd_cnt, wr_cnt, both_cnt, ir_cnt, dr_cnt, ord, gap, resp_cyc, addr_bad;
    logic [31:0]  addr_first;
    logic [255:0] wdata_first, last_rdata;

    pmem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pm_read(pm_read), .pm_write(pm_write), .pm_address(pm_address),
        .pm_wdata(pm_wdata), .pm_rdata(pm_rdata), .pm_resp(pm_resp)
    );

    always #5 clk = ~clk;

    // adaptor model: resp in the lat-th cycle of a held request, shares rst
    always @(posedge clk or posedge rst)
        if (rst) cnt <= 0;
        else cnt <= ((pm_read | pm_write) && !pm_resp) ? cnt + 1 : 0;
    assign pm_resp = (pm_read | pm_write) && (cnt == lat - 1);

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int nresp, input bit hold_i, input bit hold_d);
        int seen = 0;
        bit got_addr = 0;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; ir_cnt = 0; dr_cnt = 0;
        ord = 0; gap = 0; resp_cyc = 0; addr_bad = 0;
        for (int c = 1; c <= 200 && seen < nresp; c++) begin
            @(negedge clk);
            rd_cnt += int'(pm_read);
            wr_cnt += int'(pm_write);
            both_cnt += int'(pm_read & pm_write);
            if (pm_read | pm_write) begin
                if (!got_addr) begin
                    addr_first = pm_address;
                    wdata_first = pm_wdata;
                    got_addr = 1;
                end else if (seen == 0 && pm_address != addr_first) addr_bad++;
            end else if (seen > 0) gap++;
            if (i_resp | d_resp) begin
                seen++;
                if (seen == 1) resp_cyc = c;
                ord = ord * 10 + (d_resp ? 2 : 1);
                ir_cnt += int'(i_resp);
                dr_cnt += int'(d_resp);
                last_rdata = d_resp ? d_rdata : i_rdata;
                if (i_resp && !hold_i) i_read = 0;
                if (d_resp && !hold_d) begin d_read = 0; d_write = 0; end
            end
        end
        chk("done", seen, nresp);
        chk("rw_both", both_cnt, 0);
        i_read = 0; d_read = 0; d_write = 0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_pm_read", pm_read, 0);
        chk("rst_pm_write", pm_write, 0);
        chk("rst_i_resp", i_resp, 0);
        chk("rst_d_resp", d_resp, 0);
        chk("rst_addr", pm_address, 0);
        chk("rst_wdata", pm_wdata, 0);

        // icache-only read, offset bits cleared
        lat = 4; pm_rdata = {8{32'hDEAD_BEEF}};
        i_read = 1; i_address = 32'h0000_1234;
        run(1, 0, 0);
        chk("t1_addr", addr_first, 32'h0000_1220);
        chk("t1_rd", rd_cnt, 4);
        chk("t1_wr", wr_cnt, 0);
        chk("t1_lat", resp_cyc, 4);
        chk("t1_ir", ir_cnt, 1);
        chk("t1_dr", dr_cnt, 0);
        chk("t1_rdata", last_rdata, {8{32'hDEAD_BEEF}});

        // dcache write-back
        lat = 3;
        d_write = 1; d_address = 32'h8000_0040; d_wdata = {32{8'hA5}};
        run(1, 0, 0);
        chk("t2_addr", addr_first, 32'h8000_0040);
        chk("t2_wdata", wdata_first, {32{8'hA5}});
        chk("t2_wr", wr_cnt, 3);
        chk("t2_rd", rd_cnt, 0);
        chk("t2_dr", dr_cnt, 1);
        chk("t2_ir", ir_cnt, 0);

        // simultaneous requests
        lat = 4; pm_rdata = {8{32'h1234_5678}};
        i_read = 1; i_address = 32'h0000_0100;
        d_read = 1; d_address = 32'h0000_0200;
        run(2, 0, 0);
`ifdef PMEM_ARB_RR_EN
        chk("t3_order", ord, 12);
`else
        chk("t3_order", ord, 21);
`endif
        chk("t3_ir", ir_cnt, 1);
        chk("t3_dr", dr_cnt, 1);
        chk("t3_gap", gap, 1);
        chk("t3_rdata", last_rdata, {8{32'h1234_5678}});

        // dcache keeps requesting, icache held
        lat = 2;
        i_read = 1; d_read = 1;
        run(3, 1, 1);
`ifdef PMEM_ARB_RR_EN
        chk("t4_order", ord, 121);
        chk("t4_ir", ir_cnt, 2);
`else
        chk("t4_order", ord, 222);
        chk("t4_ir", ir_cnt, 0);
`endif

        // reset two cycles into SERVE_D
        lat = 4;
        d_read = 1; d_address = 32'h3000_0080;
        repeat (3) @(negedge clk);
        chk("t5_pre_rd", pm_read, 1);
        rst = 1;
        #1;
        chk("t5_rst_rd", pm_read, 0);
        chk("t5_rst_dresp", d_resp, 0);
        @(negedge clk);
        d_read = 0;
        rst = 0;
        @(negedge clk);
        chk("t5_post_addr", pm_address, 0);
        i_read = 1; i_address = 32'h0000_0040;
        run(1, 0, 0);
        chk("t5_ir", ir_cnt, 1);
        chk("t5_dr", dr_cnt, 0);
        chk("t5_addr", addr_first, 32'h0000_0040);
        chk("t5_lat", resp_cyc, 4);

        // i_address changed mid-SERVE_I
        lat = 5;
        i_read = 1; i_address = 32'h2000_0010;
        repeat (2) @(negedge clk);
        chk("t6_addr_mid", pm_address, 32'h2000_0000);
        i_address = 32'hFFFF_FFFF;
        run(1, 0, 0);
        chk("t6_addr_hold", addr_first, 32'h2000_0000);
        chk("t6_addr_bad", addr_bad, 0);
        chk("t6_ir", ir_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
